// File: rtl/braille_cell_driver_pkg.sv
// Shared definitions for the braille cell driver: state encoding, cell
// geometry and the grade-1 braille dot patterns for 'a'..'z'.
// Bit k of a pattern raises braille dot k+1.
package braille_cell_driver_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned NUM_LETTERS = 26;
  localparam int unsigned DOTS_W      = 6;

  localparam logic [DOTS_W-1:0] BRAILLE_LUT [NUM_LETTERS] = '{
    6'b000001,  // a
    6'b000011,  // b
    6'b001001,  // c
    6'b011001,  // d
    6'b010001,  // e
    6'b001011,  // f
    6'b011011,  // g
    6'b010011,  // h
    6'b001010,  // i
    6'b011010,  // j
    6'b000101,  // k
    6'b000111,  // l
    6'b001101,  // m
    6'b011101,  // n
    6'b010101,  // o
    6'b001111,  // p
    6'b011111,  // q
    6'b010111,  // r
    6'b001110,  // s
    6'b011110,  // t
    6'b100101,  // u
    6'b100111,  // v
    6'b111010,  // w
    6'b101101,  // x
    6'b111101,  // y
    6'b110101   // z
  };

endpackage

// File: rtl/braille_cell_driver_lut.sv
// Combinational letter-index to braille-pattern encoder.
// Indices outside 0..25 flag o_illegal and produce a blank pattern.
module braille_lut
  import braille_cell_driver_pkg::*;
#(
  parameter int unsigned ALPHA_W = 5
) (
  input  logic [ALPHA_W-1:0] i_alpha,
  output logic [DOTS_W-1:0]  o_pattern,
  output logic               o_illegal
);

  // Table lookup guarded by the legal-range check.
  always_comb begin
    o_illegal = (32'(i_alpha) >= NUM_LETTERS);
    o_pattern = '0;
    if (!o_illegal) begin
      o_pattern = BRAILLE_LUT[i_alpha];
    end
  end

endmodule

// File: rtl/braille_cell_driver.sv
// Braille cell driver: accepts letter indices over valid/ready, shows each
// letter's dot pattern for HOLD_CYCLES, blanks for GAP_CYCLES, then pulses
// o_done. A one-entry buffer queues the next letter during display.
// Optional build macro BRAILLE_PWM_EN adds i_duty[7:0] dimming of the dots
// during SHOW via a free-running 8-bit PWM counter.
module braille_cell_driver
  import braille_cell_driver_pkg::*;
#(
  parameter int unsigned ALPHA_W     = 5,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES  = 10000000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_valid,
  input  logic [ALPHA_W-1:0] i_alpha,
`ifdef BRAILLE_PWM_EN
  input  logic [7:0]         i_duty,
`endif
  output logic               o_ready,
  output logic [DOTS_W-1:0]  o_dots,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                buf_full;
  logic [DOTS_W-1:0]   buf_pat;
  logic [DOTS_W-1:0]   dots_q;
  logic                done_q;
  logic                err_q;

  logic [DOTS_W-1:0]   lut_pat;
  logic                lut_illegal;
  logic                xfer;
  logic                legal_xfer;
  logic                illegal_xfer;

  braille_lut #(
    .ALPHA_W (ALPHA_W)
  ) u_lut (
    .i_alpha   (i_alpha),
    .o_pattern (lut_pat),
    .o_illegal (lut_illegal)
  );

  // Handshake qualification: ready is simply "buffer empty".
  always_comb begin
    xfer         = i_valid & ~buf_full;
    legal_xfer   = xfer & ~lut_illegal;
    illegal_xfer = xfer & lut_illegal;
  end

  // Display sequencer with one-entry letter buffer; outputs are registered.
  // The buffer holds the encoded pattern so a pop loads dots_q directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      buf_full <= 1'b0;
      buf_pat  <= '0;
      dots_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= illegal_xfer;
      case (state)
        IDLE: begin
          if (legal_xfer) begin
            state  <= SHOW;
            dots_q <= lut_pat;
            cnt    <= '0;
          end
        end
        SHOW: begin
          if (cnt == HOLD_LAST) begin
            state  <= GAP;
            dots_q <= '0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
          if (legal_xfer) begin
            buf_full <= 1'b1;
            buf_pat  <= lut_pat;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            done_q <= 1'b1;
            cnt    <= '0;
            // Buffered letter has priority; a same-cycle transfer is only
            // possible with an empty buffer and bypasses it.
            if (buf_full) begin
              state    <= SHOW;
              dots_q   <= buf_pat;
              buf_full <= 1'b0;
            end else if (legal_xfer) begin
              state  <= SHOW;
              dots_q <= lut_pat;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (legal_xfer) begin
              buf_full <= 1'b1;
              buf_pat  <= lut_pat;
            end
          end
        end
        default: begin
          state  <= IDLE;
          dots_q <= '0;
          cnt    <= '0;
        end
      endcase
    end
  end

`ifdef BRAILLE_PWM_EN
  logic [7:0] pwm_cnt;

  // Free-running PWM phase counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Dots are non-zero only in SHOW, so masking dots_q dims just that phase.
  always_comb begin
    o_dots = dots_q & {DOTS_W{pwm_cnt < i_duty}};
  end
`else
  // Static pattern during SHOW.
  always_comb begin
    o_dots = dots_q;
  end
`endif

  // Status outputs derived from registered state.
  always_comb begin
    o_ready = ~buf_full;
    o_busy  = (state != IDLE);
    o_done  = done_q;
    o_err   = err_q;
  end

endmodule

// File: tb/tb_braille_cell_driver.sv
// Scoreboard bench for braille_cell_driver (HOLD_CYCLES=4, GAP_CYCLES=2).
// Stimulus pushes each letter's expected pattern (or an expected error) into
// queues; a negedge monitor measures show/gap run lengths and pops on o_done
// and o_err.
module tb_braille_cell_driver;

  localparam int HOLD = 4;
  localparam int GAP  = 2;

  logic       clk;
  logic       reset;
  logic       i_valid;
  logic [4:0] i_alpha;
  logic       o_ready;
  logic [5:0] o_dots;
  logic       o_busy;
  logic       o_done;
  logic       o_err;
`ifdef BRAILLE_PWM_EN
  logic [7:0] i_duty;
`endif

  int vectors     = 0;
  int miscompares = 0;

  logic [5:0] exp_q[$];
  bit          err_q[$];
  bit          mon_en = 1'b1;

  braille_cell_driver #(
    .ALPHA_W     (5),
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .CNT_W       (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_valid (i_valid),
    .i_alpha (i_alpha),
`ifdef BRAILLE_PWM_EN
    .i_duty  (i_duty),
`endif
    .o_ready (o_ready),
    .o_dots  (o_dots),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Offer one letter, waiting (bounded) for ready; returns just after the
  // transfer edge with i_valid dropped.
  task automatic send(input logic [4:0] a, input logic [5:0] pat, input bit is_err,
                      input int max_wait, output int waited);
    waited  = 0;
    i_valid = 1'b1;
    i_alpha = a;
    while (!o_ready && waited < max_wait) begin
      @(posedge clk); #1;
      waited++;
    end
    check("send_ready", {31'd0, o_ready}, 32'd1);
    if (is_err) err_q.push_back(1'b1);
    else        exp_q.push_back(pat);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (o_busy && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_timeout", {31'd0, o_busy}, 32'd0);
  endtask

  // Monitor: run-length tracking of displayed patterns and blank gaps.
  initial begin
    logic [5:0] prev_dots;
    logic [5:0] last_pat;
    int         show_len;
    int         gap_len;
    logic [5:0] e;
    prev_dots = '0; last_pat = '0; show_len = 0; gap_len = 0;
    forever begin
      @(negedge clk);
      if (reset || !mon_en) begin
        prev_dots = '0; last_pat = '0; show_len = 0; gap_len = 0;
      end else begin
        if (o_done) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_done: o_done=1 with no letter outstanding, required 0");
          end else begin
            e = exp_q.pop_front();
            if (last_pat !== e || show_len != HOLD || gap_len != GAP) begin
              miscompares++;
              $display("FAIL letter: got pattern %b show %0d gap %0d, required pattern %b show %0d gap %0d",
                       last_pat, show_len, gap_len, e, HOLD, GAP);
            end
          end
        end
        if (o_err) begin
          vectors++;
          if (err_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_err: o_err=1 with no illegal letter outstanding, required 0");
          end else begin
            void'(err_q.pop_front());
          end
        end
        if (o_dots != 6'd0) begin
          if (o_dots != prev_dots) begin
            last_pat = o_dots;
            show_len = 1;
            gap_len  = 0;
          end else begin
            show_len++;
          end
        end else begin
          gap_len++;
        end
        prev_dots = o_dots;
      end
    end
  end

`ifdef BRAILLE_PWM_EN
  logic [7:0] pwm_model;
  always @(posedge clk or posedge reset) begin
    if (reset) pwm_model <= 8'd0;
    else       pwm_model <= pwm_model + 8'd1;
  end
`endif

  initial begin
    int w;
    reset   = 1'b1;
    i_valid = 1'b0;
    i_alpha = '0;
`ifdef BRAILLE_PWM_EN
    i_duty  = 8'd255;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_dots",  {26'd0, o_dots}, 32'd0);
    check("rst_busy",  {31'd0, o_busy}, 32'd0);
    check("rst_done",  {31'd0, o_done}, 32'd0);
    check("rst_err",   {31'd0, o_err},  32'd0);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single letter 'a'
    send(5'd0, 6'b000001, 1'b0, 10, w);
    check("a_dots_latency", {26'd0, o_dots}, 32'b000001);
    check("a_busy",  {31'd0, o_busy},  32'd1);
    check("a_ready", {31'd0, o_ready}, 32'd1);
    wait_idle(20);
    check("a_idle_ready", {31'd0, o_ready}, 32'd1);
    check("a_idle_dots",  {26'd0, o_dots},  32'd0);

    // 'z' then 'c' queued in SHOW; 'e' held off until the buffer pops
    send(5'd25, 6'b110101, 1'b0, 10, w);
    send(5'd2,  6'b001001, 1'b0, 10, w);
    check("buf_full_ready", {31'd0, o_ready}, 32'd0);
    send(5'd4,  6'b010001, 1'b0, 30, w);
    check("third_held_off", {31'd0, (w > 0)}, 32'd1);
    wait_idle(60);

    // Illegal index
    send(5'd30, 6'b000000, 1'b1, 10, w);
    check("err_pulse", {31'd0, o_err},  32'd1);
    check("err_busy",  {31'd0, o_busy}, 32'd0);
    check("err_dots",  {26'd0, o_dots}, 32'd0);
    @(posedge clk); #1;
    check("err_single", {31'd0, o_err}, 32'd0);

    // Bypass: 'b', then 'd' transferred on the last gap cycle
    send(5'd1, 6'b000011, 1'b0, 10, w);
    repeat (5) @(posedge clk);
    #1;
    send(5'd3, 6'b011001, 1'b0, 10, w);
    check("bypass_dots",  {26'd0, o_dots},  32'b011001);
    check("bypass_ready", {31'd0, o_ready}, 32'd1);
    check("bypass_done",  {31'd0, o_done},  32'd1);
    wait_idle(30);

    // Async reset during SHOW with a buffered letter
    send(5'd0, 6'b000001, 1'b0, 10, w);
    send(5'd1, 6'b000011, 1'b0, 10, w);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("abort_dots",  {26'd0, o_dots},  32'd0);
    check("abort_busy",  {31'd0, o_busy},  32'd0);
    check("abort_done",  {31'd0, o_done},  32'd0);
    check("abort_err",   {31'd0, o_err},   32'd0);
    check("abort_ready", {31'd0, o_ready}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_stays_idle", {31'd0, o_busy}, 32'd0);

    @(negedge clk); #1;
    check("letters_drained", exp_q.size(), 32'd0);
    check("errs_drained",    err_q.size(), 32'd0);

`ifdef BRAILLE_PWM_EN
    begin
      int highs;
      mon_en  = 1'b0;
      i_duty  = 8'd0;
      i_valid = 1'b1;
      i_alpha = 5'd0;
      repeat (300) begin
        @(negedge clk);
        check("pwm_dark", {26'd0, o_dots}, 32'd0);
      end
      i_duty = 8'd128;
      highs  = 0;
      repeat (600) begin
        @(negedge clk);
        if (o_dots[0]) highs++;
        check("pwm_mask", {31'd0, ((o_dots[5:1] == 5'd0) && (!o_dots[0] || pwm_model < 8'd128))}, 32'd1);
      end
      check("pwm_some_on", {31'd0, (highs > 0)}, 32'd1);
      i_valid = 1'b0;
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
